mult_share_arbiter: RTL

Arbitrates two requesters onto one shared shift-add multiplier. The multiplier is sequenced by a start/finish controller. The block accepts operand pairs over valid/ready handshakes and grants round-robin. It launches the multiplier with a one-cycle start pulse, waits for finish (with a watchdog), and returns the product to the winning requester. It sits between the client logic and the multiplier datapath/controller pair.

---
 rtl/mult_share_pkg.sv | 17 +
 rtl/mult_share_arbiter_rr_arbiter2.sv | 21 ++
 rtl/mult_share_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int DEF_N       = 4;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// whichever requester was not granted last.
module rr_arbiter2
    import mult_share_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant selection from the current valids and the last winner
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = (last_grant == REQ1) ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Arbitrates two requesters onto one shared multiplier: accepts an operand
// pair, launches the multiplier with a single start pulse, waits for finish
// under a watchdog, then pulses the result back to the requester that won.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp0_valid,
    output logic           rsp1_valid,
    output logic [2*N-1:0] rsp_product,
    output logic           rsp_error,
    output logic           mul_start,
    output logic [N-1:0]   mul_a,
    output logic [N-1:0]   mul_b,
    input  logic           mul_finish,
    input  logic [2*N-1:0] mul_product,
    output logic           busy
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         state;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [2*N-1:0] product_q;
    logic           error_q;
    logic           owner;
    logic           last_grant;
    logic [CW-1:0]  wd_cnt;
    logic [1:0]     grant;
    logic           accept;

    rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = (state == IDLE) & grant[REQ0];
    assign req1_ready = (state == IDLE) & grant[REQ1];
    assign accept     = req0_ready | req1_ready;

    assign mul_start   = (state == LAUNCH);
    assign mul_a       = op_a;
    assign mul_b       = op_b;
    assign busy        = (state != IDLE);
    assign rsp0_valid  = (state == RESPOND) & (owner == REQ0);
    assign rsp1_valid  = (state == RESPOND) & (owner == REQ1);
    assign rsp_product = product_q;
    assign rsp_error   = error_q;

    // Sequencer: accept, launch, wait for finish or watchdog, respond
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            product_q  <= '0;
            error_q    <= 1'b0;
            owner      <= REQ0;
            last_grant <= REQ1;
            wd_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant[REQ1] ? req1_a : req0_a;
                        op_b       <= grant[REQ1] ? req1_b : req0_b;
                        owner      <= grant[REQ1] ? REQ1 : REQ0;
                        last_grant <= grant[REQ1] ? REQ1 : REQ0;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // finish takes priority over a watchdog expiring the same cycle
                    if (mul_finish) begin
                        product_q <= mul_product;
                        error_q   <= 1'b0;
                        state     <= RESPOND;
                    end else if (wd_cnt == CNT_LAST) begin
                        product_q <= '0;
                        error_q   <= 1'b1;
                        state     <= RESPOND;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
